core_mem_requester: RTL

- Core-side initiator for the shared-memory bus: the other end of the memory responder's read/write interface.
- Accepts one command at a time from a core (opcode, addr, wdata). Arbitrates for the bus via req/gnt tagged with core_id, issues a single-cycle read_en/write_en access, waits for valid_out on reads, and returns the result to the core over a valid/ready response channel.
- One instance per core; four instances share one arbiter and one memory.

---
 rtl/core_mem_requester_if.sv | 48 ++++
 rtl/core_mem_requester.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/core_mem_requester_if.sv
// ---------------------------------------------------------------------------
// core_mem_requester_if
//
// Shared-memory bus as seen by one core's requester: arbitration (req/gnt
// tagged with core_id) plus the memory responder's single-cycle read/write
// strobe interface.
//
// Signals:
//   req        requester -> arbiter  bus request
//   gnt        arbiter -> requester  bus grant (held while req is high)
//   core_id    requester -> arbiter  identifier of the requesting core
//   opcode     requester -> memory   4'h1 read, 4'h2 write
//   addr       requester -> memory   access address
//   data_in    requester -> memory   write data
//   write_en   requester -> memory   single-cycle write strobe
//   read_en    requester -> memory   single-cycle read strobe
//   data_out   memory -> requester   read data
//   valid_out  memory -> requester   read data valid
//
// Modports:
//   master  the core-side requester
//   slave   the arbiter / memory side
// ---------------------------------------------------------------------------
interface core_mem_requester_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 8
);
    logic                  req;
    logic                  gnt;
    logic [1:0]            core_id;
    logic [3:0]            opcode;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  write_en;
    logic                  read_en;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;

    modport master (
        output req, core_id, opcode, addr, data_in, write_en, read_en,
        input  gnt, data_out, valid_out
    );

    modport slave (
        input  req, core_id, opcode, addr, data_in, write_en, read_en,
        output gnt, data_out, valid_out
    );
endinterface

// File: rtl/core_mem_requester.sv
// ---------------------------------------------------------------------------
// core_mem_requester
//
// Core-side initiator for the shared-memory bus. Accepts one command at a
// time from a core, arbitrates for the bus, performs a single-cycle read or
// write access, waits for read data, and returns the result over a
// valid/ready response channel. One instance per core.
//
// Parameters:
//   ADDR_WIDTH      memory address width
//   DATA_WIDTH      memory data width
//   CORE_ID         2-bit identifier driven on core_id while requesting
//   TIMEOUT_CYCLES  read-wait limit in cycles (only with REQ_TIMEOUT_EN)
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   cmd_valid    core command valid
//   cmd_ready    requester can accept a command
//   cmd_opcode   4'h1 read, 4'h2 write, anything else is illegal
//   cmd_addr     command address
//   cmd_wdata    command write data
//   rsp_valid    response valid
//   rsp_ready    core accepts response
//   rsp_data     read data (0 for writes and errors)
//   rsp_err      illegal opcode or read timeout
//   bus          shared-memory bus, master side
//
// Build option:
//   REQ_TIMEOUT_EN  when defined, a read that gets no valid_out within
//                   TIMEOUT_CYCLES cycles of waiting completes with rsp_err.
//                   When undefined the read wait is unbounded.
//
// All outputs are registered: each output register is loaded from the
// next-state value, so outputs always reflect the current state.
// ---------------------------------------------------------------------------
module core_mem_requester #(
    parameter int         ADDR_WIDTH     = 11,
    parameter int         DATA_WIDTH     = 8,
    parameter logic [1:0] CORE_ID        = 2'd0,
    parameter int         TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [3:0]            cmd_opcode,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err,

    core_mem_requester_if.master  bus
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_REQ     = 3'd1;
    localparam logic [2:0] ST_ACCESS  = 3'd2;
    localparam logic [2:0] ST_WAIT_RD = 3'd3;
    localparam logic [2:0] ST_RESP    = 3'd4;

    localparam logic [3:0] OP_READ  = 4'h1;
    localparam logic [3:0] OP_WRITE = 4'h2;

    logic [2:0]            state_q;
    logic [2:0]            state_d;

    // Captured command.
    logic [3:0]            op_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    // Command as it will be held after this edge (bypasses the capture
    // registers on the accept cycle so REQ outputs are correct at once).
    logic [3:0]            op_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] wdata_d;

    logic                  cmd_fire;
    logic                  op_legal;
    logic                  rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_data_d;
    logic                  bus_busy_d;
    logic                  rd_wait_to;

    assign cmd_fire = (state_q == ST_IDLE) && cmd_valid && cmd_ready;
    assign op_legal = (cmd_opcode == OP_READ) || (cmd_opcode == OP_WRITE);

    assign op_d    = cmd_fire ? cmd_opcode : op_q;
    assign addr_d  = cmd_fire ? cmd_addr   : addr_q;
    assign wdata_d = cmd_fire ? cmd_wdata  : wdata_q;

`ifdef REQ_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt_q;

    // Counts WAIT_RD cycles; zero on the first WAIT_RD cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt_q <= '0;
        end else if (state_q == ST_WAIT_RD) begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end else begin
            to_cnt_q <= '0;
        end
    end

    assign rd_wait_to = (to_cnt_q == TO_LAST);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign rd_wait_to         = 1'b0;
`endif

    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case statement leaves one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        rsp_err_d  = rsp_err;
        rsp_data_d = rsp_data;

        case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    if (op_legal) begin
                        state_d = ST_REQ;
                    end else begin
                        state_d    = ST_RESP;
                        rsp_err_d  = 1'b1;
                        rsp_data_d = '0;
                    end
                end
            end

            ST_REQ: begin
                if (bus.gnt) begin
                    state_d = ST_ACCESS;
                end
            end

            ST_ACCESS: begin
                // Grant and any valid_out are ignored here.
                if (op_q == OP_WRITE) begin
                    state_d    = ST_RESP;
                    rsp_err_d  = 1'b0;
                    rsp_data_d = '0;
                end else begin
                    state_d = ST_WAIT_RD;
                end
            end

            ST_WAIT_RD: begin
                // Data arriving on the last allowed cycle still wins.
                if (bus.valid_out) begin
                    state_d    = ST_RESP;
                    rsp_err_d  = 1'b0;
                    rsp_data_d = bus.data_out;
                end else if (rd_wait_to) begin
                    state_d    = ST_RESP;
                    rsp_err_d  = 1'b1;
                    rsp_data_d = '0;
                end
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    state_d    = ST_IDLE;
                    rsp_err_d  = 1'b0;
                    rsp_data_d = '0;
                end
            end

            default: begin
                state_d    = ST_IDLE;
                rsp_err_d  = 1'b0;
                rsp_data_d = '0;
            end
        endcase
    end

    assign bus_busy_d = (state_d == ST_REQ) || (state_d == ST_ACCESS) ||
                        (state_d == ST_WAIT_RD);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The captured command is reset as well; it is a handful of flops, not a
    // memory array, and a known value keeps the bus outputs clean.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (cmd_fire) begin
            op_q    <= cmd_opcode;
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
        end
    end

    // Registered outputs, decoded from the next state. Reset is asynchronous
    // so req and the strobes drop the moment reset_n falls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_err      <= 1'b0;
            rsp_data     <= '0;
            bus.req      <= 1'b0;
            bus.core_id  <= 2'b0;
            bus.opcode   <= 4'h0;
            bus.addr     <= '0;
            bus.data_in  <= '0;
            bus.write_en <= 1'b0;
            bus.read_en  <= 1'b0;
        end else begin
            cmd_ready    <= (state_d == ST_IDLE);
            rsp_valid    <= (state_d == ST_RESP);
            rsp_err      <= rsp_err_d;
            rsp_data     <= rsp_data_d;
            bus.req      <= bus_busy_d;
            bus.core_id  <= bus_busy_d ? CORE_ID : 2'b0;
            bus.opcode   <= bus_busy_d ? op_d : 4'h0;
            bus.addr     <= ((state_d == ST_ACCESS) || (state_d == ST_WAIT_RD))
                            ? addr_d : '0;
            bus.data_in  <= ((state_d == ST_ACCESS) && (op_d == OP_WRITE))
                            ? wdata_d : '0;
            bus.write_en <= (state_d == ST_ACCESS) && (op_d == OP_WRITE);
            bus.read_en  <= (state_d == ST_ACCESS) && (op_d == OP_READ);
        end
    end

endmodule
